// File: rtl/hazard_stall_unit_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : hazard_stall_unit_pkg                                         |
// | Purpose  : Shared definitions for the pipeline hazard controller:        |
// |            register-index width, x0 index, state encoding, the bundle   |
// |            of pipeline control outputs and the load-use compare.         |
// | Ports    : none (package)                                                |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package hazard_stall_unit_pkg;

  localparam int REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] REG_X0 = 5'd0;

  // State encoding
  localparam logic [1:0] ENC_RUN        = 2'd0;
  localparam logic [1:0] ENC_LOAD_STALL = 2'd1;
  localparam logic [1:0] ENC_MEM_WAIT   = 2'd2;
  localparam logic [1:0] ENC_ERROR      = 2'd3;

  typedef enum logic [1:0] {
    RUN        = ENC_RUN,
    LOAD_STALL = ENC_LOAD_STALL,
    MEM_WAIT   = ENC_MEM_WAIT,
    ERROR      = ENC_ERROR
  } state_t;

  // All pipeline control outputs, MSB first in port order.
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic id_ex_write;
    logic ex_mem_write;
    logic id_ex_bubble;
    logic if_id_flush;
    logic id_ex_flush;
    logic mem_wb_bubble;
  } ctrl_t;

  // Everything advances, nothing is cleared.
  localparam ctrl_t CTRL_DEFAULT    = ctrl_t'(8'b1111_0000);
  // Hold PC and IF/ID, inject a NOP into ID/EX so the load moves ahead alone.
  localparam ctrl_t CTRL_LOAD_STALL = ctrl_t'(8'b0011_1000);
  // Wrong-path instructions in IF/ID and ID/EX are squashed.
  localparam ctrl_t CTRL_FLUSH      = ctrl_t'(8'b1111_0110);
  // Whole front of the pipe holds; WB gets a NOP while MEM is stuck.
  localparam ctrl_t CTRL_FREEZE     = ctrl_t'(8'b0000_0001);
  // Nothing moves while reset is asserted.
  localparam ctrl_t CTRL_RESET      = ctrl_t'(8'b0000_0000);

  // Load in EX writes a register that the instruction in ID actually reads.
  // x0 is hardwired zero, so a load targeting it can never create a hazard.
  function automatic logic load_use_hazard(
    input logic                 mem_read_ex,
    input logic [REG_IDX_W-1:0] rd_ex,
    input logic [REG_IDX_W-1:0] rs1_id,
    input logic                 use_rs1,
    input logic [REG_IDX_W-1:0] rs2_id,
    input logic                 use_rs2
  );
    logic hit1;
    logic hit2;
    hit1 = use_rs1 && (rs1_id == rd_ex);
    hit2 = use_rs2 && (rs2_id == rd_ex);
    return mem_read_ex && (rd_ex != REG_X0) && (hit1 || hit2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_stall_unit_sat_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sat_counter                                                   |
// | Purpose  : Up-counter that sticks at all-ones instead of wrapping.       |
// | Ports    : clk    - clock                                                |
// |            arst_n - asynchronous active-low reset (count -> 0)           |
// |            inc    - count this cycle                                     |
// |            clear  - synchronous clear, wins over inc                     |
// |            count  - current count                                        |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hazard_stall_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : hazard_stall_unit                                             |
// | Purpose  : Hazard controller for the 5-stage core. Resolves load-use     |
// |            hazards (stall + bubble), taken branches (flush IF/ID and     |
// |            ID/EX) and data-memory waits (full freeze), with a timeout    |
// |            on memory waits and a saturating stall-cycle counter.        |
// | Ports    : clk, arst_n              - clock, async active-low reset      |
// |            Rs1_ID, Rs2_ID           - source regs of instruction in ID   |
// |            use_rs1_ID, use_rs2_ID   - ID instruction reads Rs1/Rs2       |
// |            Rd_ID_EX, MemRead_ID_EX  - dest reg / is-load of EX instr     |
// |            branch_taken_EX          - branch resolved taken in EX        |
// |            mem_req_MEM, mem_ready   - MEM access pending / completing    |
// |            PC_write .. EX_MEM_write - pipeline register enables          |
// |            ID_EX_bubble, IF_ID_flush, ID_EX_flush, MEM_WB_bubble         |
// |                                     - NOP injection / clear controls     |
// |            hazard_err               - sticky memory-timeout error        |
// |            stall_cycles             - saturating count of PC stalls      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic [REG_IDX_W-1:0] Rs1_ID,
  input  logic [REG_IDX_W-1:0] Rs2_ID,
  input  logic                 use_rs1_ID,
  input  logic                 use_rs2_ID,
  input  logic [REG_IDX_W-1:0] Rd_ID_EX,
  input  logic                 MemRead_ID_EX,
  input  logic                 branch_taken_EX,
  input  logic                 mem_req_MEM,
  input  logic                 mem_ready,
  output logic                 PC_write,
  output logic                 IF_ID_write,
  output logic                 ID_EX_write,
  output logic                 EX_MEM_write,
  output logic                 ID_EX_bubble,
  output logic                 IF_ID_flush,
  output logic                 ID_EX_flush,
  output logic                 MEM_WB_bubble,
  output logic                 hazard_err,
  output logic [CNT_W-1:0]     stall_cycles
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);

  state_t              state;
  state_t              state_nxt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [WAIT_W-1:0]   wait_cnt_nxt;
  ctrl_t               ctrl;
  logic                luh;
  logic                memwait;

  assign luh = load_use_hazard(MemRead_ID_EX, Rd_ID_EX,
                               Rs1_ID, use_rs1_ID,
                               Rs2_ID, use_rs2_ID);

  // A MEM instruction that withdraws its request is as good as completed.
  assign memwait = mem_req_MEM && !mem_ready;

  // ---------------------------------------------------------------------
  // State, wait counter and sticky error
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state      <= RUN;
      wait_cnt   <= '0;
      hazard_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (state_nxt == ERROR) begin
        hazard_err <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Next state and Mealy control outputs
  // ---------------------------------------------------------------------
  always_comb begin
    ctrl         = CTRL_DEFAULT;
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;

    unique case (state)
      RUN: begin
        if (memwait) begin
          ctrl         = CTRL_FREEZE;
          wait_cnt_nxt = WAIT_ONE;
          state_nxt    = MEM_WAIT;
        end else if (branch_taken_EX) begin
          // The stalled consumer is on the wrong path; flushing it is enough.
          ctrl = CTRL_FLUSH;
        end else if (luh) begin
          ctrl      = CTRL_LOAD_STALL;
          state_nxt = LOAD_STALL;
        end
      end

      LOAD_STALL: begin
        // The load has moved on to MEM, so the same ID instruction is now
        // covered by forwarding; luh is deliberately not looked at here.
        state_nxt = RUN;
        if (memwait) begin
          ctrl         = CTRL_FREEZE;
          wait_cnt_nxt = WAIT_ONE;
          state_nxt    = MEM_WAIT;
        end else if (branch_taken_EX) begin
          ctrl = CTRL_FLUSH;
        end
      end

      MEM_WAIT: begin
        if (!memwait) begin
          // Release cycle: everything advances; EX-stage decisions are
          // picked up again from RUN on the following cycle.
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end else begin
          ctrl = CTRL_FREEZE;
          if (wait_cnt == WAIT_LIMIT) begin
            state_nxt = ERROR;
          end else begin
            wait_cnt_nxt = wait_cnt + 1'b1;
          end
        end
      end

      ERROR: begin
        ctrl = CTRL_FREEZE;
      end

      default: begin
        ctrl      = CTRL_FREEZE;
        state_nxt = RUN;
      end
    endcase

    // Nothing may advance while reset is held, whatever the state says.
    if (!arst_n) begin
      ctrl = CTRL_RESET;
    end
  end

  assign PC_write      = ctrl.pc_write;
  assign IF_ID_write   = ctrl.if_id_write;
  assign ID_EX_write   = ctrl.id_ex_write;
  assign EX_MEM_write  = ctrl.ex_mem_write;
  assign ID_EX_bubble  = ctrl.id_ex_bubble;
  assign IF_ID_flush   = ctrl.if_id_flush;
  assign ID_EX_flush   = ctrl.id_ex_flush;
  assign MEM_WB_bubble = ctrl.mem_wb_bubble;

  // ---------------------------------------------------------------------
  // Stall statistics: every cycle the PC is held counts, whatever the cause
  // ---------------------------------------------------------------------
  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk    (clk),
    .arst_n (arst_n),
    .inc    (!ctrl.pc_write),
    .clear  (1'b0),
    .count  (stall_cycles)
  );

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_hazard_stall_unit                                          |
// | Purpose  : Directed self-checking bench for hazard_stall_unit, built     |
// |            with a short memory timeout and a narrow stall counter.      |
// | Ports    : none                                                          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_hazard_stall_unit;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 4;

  // {PC, IF_ID, ID_EX, EX_MEM write, ID_EX_bubble, IF_ID_flush, ID_EX_flush, MEM_WB_bubble}
  localparam logic [7:0] DEF = 8'b1111_0000;
  localparam logic [7:0] LUS = 8'b0011_1000;
  localparam logic [7:0] BRF = 8'b1111_0110;
  localparam logic [7:0] FRZ = 8'b0000_0001;
  localparam logic [7:0] RSV = 8'b0000_0000;

  logic             clk = 1'b0;
  logic             arst_n;
  logic [4:0]       Rs1_ID, Rs2_ID, Rd_ID_EX;
  logic             use_rs1_ID, use_rs2_ID, MemRead_ID_EX;
  logic             branch_taken_EX, mem_req_MEM, mem_ready;
  logic             PC_write, IF_ID_write, ID_EX_write, EX_MEM_write;
  logic             ID_EX_bubble, IF_ID_flush, ID_EX_flush, MEM_WB_bubble;
  logic             hazard_err;
  logic [CNT_W-1:0] stall_cycles;
  logic [7:0]       ctrl_obs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_stall_unit #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk             (clk),
    .arst_n          (arst_n),
    .Rs1_ID          (Rs1_ID),
    .Rs2_ID          (Rs2_ID),
    .use_rs1_ID      (use_rs1_ID),
    .use_rs2_ID      (use_rs2_ID),
    .Rd_ID_EX        (Rd_ID_EX),
    .MemRead_ID_EX   (MemRead_ID_EX),
    .branch_taken_EX (branch_taken_EX),
    .mem_req_MEM     (mem_req_MEM),
    .mem_ready       (mem_ready),
    .PC_write        (PC_write),
    .IF_ID_write     (IF_ID_write),
    .ID_EX_write     (ID_EX_write),
    .EX_MEM_write    (EX_MEM_write),
    .ID_EX_bubble    (ID_EX_bubble),
    .IF_ID_flush     (IF_ID_flush),
    .ID_EX_flush     (ID_EX_flush),
    .MEM_WB_bubble   (MEM_WB_bubble),
    .hazard_err      (hazard_err),
    .stall_cycles    (stall_cycles)
  );

  assign ctrl_obs = {PC_write, IF_ID_write, ID_EX_write, EX_MEM_write,
                     ID_EX_bubble, IF_ID_flush, ID_EX_flush, MEM_WB_bubble};

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic clr_inputs();
    Rs1_ID = 5'd0; Rs2_ID = 5'd0; Rd_ID_EX = 5'd0;
    use_rs1_ID = 1'b0; use_rs2_ID = 1'b0; MemRead_ID_EX = 1'b0;
    branch_taken_EX = 1'b0; mem_req_MEM = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic set_lu_rs1(input logic [4:0] r);
    MemRead_ID_EX = 1'b1; Rd_ID_EX = r; Rs1_ID = r; use_rs1_ID = 1'b1;
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  initial begin
    clr_inputs();
    arst_n = 1'b0;

    // ---------------- reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ctrl", ctrl_obs, RSV);
    chk("rst_err",  8'(hazard_err), 8'd0);
    chk("rst_cnt",  8'(stall_cycles), 8'd0);
    @(negedge clk); arst_n = 1'b1;

    // ---------------- load-use on Rs1, then masked LOAD_STALL cycle
    @(negedge clk); set_lu_rs1(5'd5);
    #1 chk("lu_rs1", ctrl_obs, LUS);
    @(negedge clk);
    #1 chk("lu_mask", ctrl_obs, DEF);
    chk("lu_cnt", 8'(stall_cycles), 8'd1);
    @(negedge clk); clr_inputs();
    #1 chk("lu_back_run", ctrl_obs, DEF);

    // ---------------- x0 and unused operands never stall
    @(negedge clk); clr_inputs();
    MemRead_ID_EX = 1'b1; Rd_ID_EX = 5'd0; Rs2_ID = 5'd0; use_rs2_ID = 1'b1;
    #1 chk("x0_no_stall", ctrl_obs, DEF);
    @(negedge clk); clr_inputs();
    MemRead_ID_EX = 1'b1; Rd_ID_EX = 5'd7; Rs1_ID = 5'd7; Rs2_ID = 5'd3; use_rs2_ID = 1'b1;
    #1 chk("unused_rs1", ctrl_obs, DEF);
    @(negedge clk); clr_inputs();
    MemRead_ID_EX = 1'b1; Rd_ID_EX = 5'd9; Rs2_ID = 5'd9; use_rs2_ID = 1'b1;
    #1 chk("lu_rs2", ctrl_obs, LUS);
    @(negedge clk); clr_inputs();
    #1 chk("ls_default", ctrl_obs, DEF);
    chk("ls_cnt", 8'(stall_cycles), 8'd2);

    // ---------------- branch beats load-use, state stays RUN
    @(negedge clk); set_lu_rs1(5'd5); branch_taken_EX = 1'b1;
    #1 chk("br_over_lu", ctrl_obs, BRF);
    @(negedge clk); branch_taken_EX = 1'b0;
    #1 chk("br_stayed_run", ctrl_obs, LUS);
    chk("br_cnt", 8'(stall_cycles), 8'd2);
    @(negedge clk); clr_inputs();
    #1 chk("br_ls_default", ctrl_obs, DEF);
    chk("br_ls_cnt", 8'(stall_cycles), 8'd3);

    // ---------------- reset pulse clears the counter
    @(negedge clk); arst_n = 1'b0;
    #1 chk("rst2_cnt", 8'(stall_cycles), 8'd0);
    @(negedge clk); arst_n = 1'b1;

    // ---------------- memory wait: 3 freeze cycles then release
    @(negedge clk); mem_req_MEM = 1'b1; mem_ready = 1'b0;
    #1 chk("mw_1", ctrl_obs, FRZ);
    @(negedge clk); branch_taken_EX = 1'b1;
    #1 chk("mw_2_br_ignored", ctrl_obs, FRZ);
    @(negedge clk); branch_taken_EX = 1'b0;
    #1 chk("mw_3", ctrl_obs, FRZ);
    @(negedge clk); mem_ready = 1'b1;
    #1 chk("mw_release", ctrl_obs, DEF);
    chk("mw_cnt", 8'(stall_cycles), 8'd3);
    @(negedge clk); clr_inputs();
    #1 chk("mw_after", ctrl_obs, DEF);
    chk("mw_cnt_hold", 8'(stall_cycles), 8'd3);

    // ---------------- timeout: 5 freeze cycles, then ERROR
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk); mem_req_MEM = 1'b1; mem_ready = 1'b0;
      #1 chk($sformatf("to_frz_%0d", k), ctrl_obs, FRZ);
      chk($sformatf("to_noerr_%0d", k), 8'(hazard_err), 8'd0);
    end
    @(negedge clk);
    #1 chk("to_err", 8'(hazard_err), 8'd1);
    chk("to_cnt", 8'(stall_cycles), 8'd8);
    @(negedge clk); mem_ready = 1'b1;
    #1 chk("err_frozen", ctrl_obs, FRZ);
    chk("err_sticky", 8'(hazard_err), 8'd1);
    @(negedge clk); clr_inputs();
    #1 chk("err_no_exit", ctrl_obs, FRZ);

    // ---------------- saturation of the 4-bit counter
    repeat (20) @(negedge clk);
    #1 chk("sat_15", 8'(stall_cycles), 8'd15);
    chk("sat_err", 8'(hazard_err), 8'd1);

    // ---------------- asynchronous reset out of ERROR
    @(negedge clk); #2 arst_n = 1'b0;
    #1 chk("rst3_err", 8'(hazard_err), 8'd0);
    chk("rst3_cnt", 8'(stall_cycles), 8'd0);
    chk("rst3_ctrl", ctrl_obs, RSV);
    @(negedge clk); arst_n = 1'b1;
    @(negedge clk);
    #1 chk("post_rst_run", ctrl_obs, DEF);

    // ---------------- dropped request releases MEM_WAIT
    @(negedge clk); mem_req_MEM = 1'b1; mem_ready = 1'b0;
    #1 chk("drop_frz", ctrl_obs, FRZ);
    @(negedge clk); mem_req_MEM = 1'b1;
    #1 chk("drop_frz2", ctrl_obs, FRZ);
    @(negedge clk); mem_req_MEM = 1'b0;
    #1 chk("drop_release", ctrl_obs, DEF);
    @(negedge clk);
    #1 chk("drop_cnt", 8'(stall_cycles), 8'd2);

    // ---------------- memory wait arriving during LOAD_STALL
    @(negedge clk); set_lu_rs1(5'd12);
    #1 chk("ls2_lu", ctrl_obs, LUS);
    @(negedge clk); clr_inputs(); mem_req_MEM = 1'b1;
    #1 chk("ls2_memwait", ctrl_obs, FRZ);
    @(negedge clk); mem_ready = 1'b1;
    #1 chk("ls2_release", ctrl_obs, DEF);
    chk("ls2_cnt", 8'(stall_cycles), 8'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Pipeline hazard controller; resolves the hazards that forwarding cannot, by stalling, bubbling and flushing.
- Covers load-use stalls, taken-branch flushes and data-memory wait freezes in the 5-stage core.
- Drives pipeline-register write enables and flush controls.
- Tracks memory-wait duration and stall statistics.

Parameters:
- MEM_TIMEOUT, 16, maximum consecutive memory-wait cycles before a fatal error.
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  core clock.
- arst_n  in  1  asynchronous active-low reset.
- Rs1_ID  in  5  source register 1 of the instruction in ID.
- Rs2_ID  in  5  source register 2 of the instruction in ID.
- use_rs1_ID  in  1  instruction in ID reads Rs1.
- use_rs2_ID  in  1  instruction in ID reads Rs2.
- Rd_ID_EX  in  5  destination register of the instruction in EX.
- MemRead_ID_EX  in  1  instruction in EX is a load.
- branch_taken_EX  in  1  branch/jump resolved taken in EX.
- mem_req_MEM  in  1  instruction in MEM accesses data memory.
- mem_ready  in  1  data memory completes the access this cycle.
- PC_write  out  1  PC update enable.
- IF_ID_write  out  1  IF/ID register enable.
- ID_EX_write  out  1  ID/EX register enable.
- EX_MEM_write  out  1  EX/MEM register enable.
- ID_EX_bubble  out  1  load zeros (NOP) into ID/EX.
- IF_ID_flush  out  1  clear IF/ID.
- ID_EX_flush  out  1  clear ID/EX.
- MEM_WB_bubble  out  1  load NOP into MEM/WB.
- hazard_err  out  1  sticky memory-timeout error.
- stall_cycles  out  CNT_W  saturating count of cycles with PC_write=0.

Behaviour:
- State, counters and hazard_err are registered. Control outputs are combinational (Mealy) from state and inputs, so they take effect with 0-cycle latency.
- Reset (arst_n=0, asynchronous):
  - state=RUN, wait_cnt=0, hazard_err=0, stall_cycles=0.
  - All write enables are forced 0; all bubble/flush outputs are forced 0.
- Default outputs: all writes=1, all bubble/flush=0.
- Load-use hazard (luh):
  - luh = MemRead_ID_EX & (Rd_ID_EX!=0) & ((use_rs1_ID & Rs1_ID==Rd_ID_EX) | (use_rs2_ID & Rs2_ID==Rd_ID_EX)).
  - Register x0 never causes a stall.
- memwait = mem_req_MEM & ~mem_ready.
- States: RUN, LOAD_STALL, MEM_WAIT, ERROR.
- Priority in RUN and LOAD_STALL: memwait > branch_taken_EX > luh (luh is evaluated in RUN only).
- RUN:
  - memwait: PC_write=IF_ID_write=ID_EX_write=EX_MEM_write=0, MEM_WB_bubble=1; wait_cnt<=1; go to MEM_WAIT.
  - else branch_taken_EX: IF_ID_flush=ID_EX_flush=1, writes=1, stay in RUN. A concurrent luh is discarded.
  - else luh: PC_write=IF_ID_write=0, ID_EX_bubble=1; go to LOAD_STALL.
- LOAD_STALL:
  - Lasts exactly one cycle; luh is masked.
  - memwait -> MEM_WAIT with freeze outputs as in RUN.
  - branch_taken_EX -> flush as in RUN, then RUN.
  - Otherwise default outputs, then RUN.
- MEM_WAIT:
  - Freeze outputs every cycle; flush outputs are 0 and branch_taken_EX is ignored.
  - mem_ready=1: release cycle uses default outputs; go to RUN; wait_cnt<=0. branch_taken_EX/luh are re-evaluated in RUN on the following cycles.
  - ~mem_ready & wait_cnt==MEM_TIMEOUT: go to ERROR.
  - Otherwise wait_cnt<=wait_cnt+1.
  - mem_req_MEM dropping to 0 while in MEM_WAIT is treated as ready.
- ERROR:
  - hazard_err=1, sticky; permanent freeze; MEM_WB_bubble=1.
  - Exits only via reset.
- stall_cycles: increments on every out-of-reset cycle with PC_write=0; saturates at all-ones with no wrap.
- wait_cnt width is clog2(MEM_TIMEOUT+1).
- Reset asserted in any state, including mid MEM_WAIT: immediate return to reset values.

Decomposition:
- Shared pipeline package holds:
  - State encoding localparams: RUN=2'd0, LOAD_STALL=2'd1, MEM_WAIT=2'd2, ERROR=2'd3.
  - REG_X0=5'd0.
  - Register-index width 5.
- Sub-module sat_counter (parameter W; inc, clear, count out), used for stall_cycles.
- The FSM and hazard compare logic stay in the top level.

Test Plan:
- Load-use on Rs1: MemRead_ID_EX=1, Rd_ID_EX=5, Rs1_ID=5, use_rs1_ID=1 -> that cycle PC_write=0, IF_ID_write=0, ID_EX_bubble=1. Next cycle, with inputs unchanged, outputs are default (LOAD_STALL mask). stall_cycles=1.
- x0 / unused operand: Rd_ID_EX=0=Rs2_ID with use_rs2=1, and separately Rs1 match with use_rs1=0 -> no stall in either case.
- Branch vs load-use in the same cycle: branch_taken_EX=1 with luh true -> IF_ID_flush=ID_EX_flush=1, ID_EX_bubble=0, PC_write=1, state stays RUN.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then 1 -> 3 freeze cycles with MEM_WB_bubble=1; the 4th cycle uses default outputs; stall_cycles=3.
- Timeout: MEM_TIMEOUT=4, mem_ready held 0 -> hazard_err rises after cycle 5 and stays 1 after mem_ready=1. arst_n pulse clears hazard_err, stall_cycles and state.
- Saturation: CNT_W=4, freeze for 20 cycles -> stall_cycles holds 15.
